// File: rtl/hdd_dpll_loop_filter.sv
// Phase detector and PI loop filter for the HDD digital PLL.
// Samples the NCO phase at each qualified flux edge, filters the error
// through a saturating proportional-integral path and emits a signed
// correction two cycles later. Also runs the IDLE/ACQUIRE/TRACK lock
// machine with gain switching and an edge-starvation timeout.
module hdd_dpll_loop_filter #(
    parameter int unsigned KP_SHIFT_ACQ   = 2,
    parameter int unsigned KI_SHIFT_ACQ   = 6,
    parameter int unsigned KP_SHIFT_TRK   = 4,
    parameter int unsigned KI_SHIFT_TRK   = 10,
    parameter logic [15:0] ERR_WIN        = 16'h1000,
    parameter int unsigned LOCK_COUNT     = 16,
    parameter int unsigned UNLOCK_COUNT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flux_edge,
    input  logic [31:0] phase_accum,
    output logic [15:0] phase_adj,
    output logic        phase_adj_valid,
    output logic [15:0] phase_err,
    output logic        locked,
    output logic [1:0]  lock_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_TRK  = 2'b10
    } state_t;

    localparam logic [4:0]  KP_ACQ  = 5'(KP_SHIFT_ACQ);
    localparam logic [4:0]  KI_ACQ  = 5'(KI_SHIFT_ACQ);
    localparam logic [4:0]  KP_TRK  = 5'(KP_SHIFT_TRK);
    localparam logic [4:0]  KI_TRK  = 5'(KI_SHIFT_TRK);
    localparam logic [8:0]  LOCK_N  = 9'(LOCK_COUNT);
    localparam logic [8:0]  UNLCK_N = 9'(UNLOCK_COUNT);
    localparam logic [15:0] TMO_N   = 16'(TIMEOUT_CYCLES);

    // Pipeline stage 1: registered edge qualifier and raw error.
    logic               r_s1_valid;
    logic signed [15:0] r_s1_err;

    // Loop state registered at stage 2.
    state_t             r_state,      w_state_nxt;
    logic signed [23:0] r_integ,      w_integ_nxt;
    logic [7:0]         r_lock_cnt,   w_lock_nxt;
    logic [7:0]         r_unlock_cnt, w_unlock_nxt;
    logic [15:0]        r_idle_cnt,   w_idle_nxt;
    logic [15:0]        r_phase_adj,  w_adj_nxt;
    logic [15:0]        r_phase_err,  w_err_nxt;
    logic               r_adj_valid,  w_valid_nxt;

    // Stage-2 datapath.
    logic               w_accept;
    logic [4:0]         w_kp, w_ki;
    logic signed [24:0] w_e_ext, w_integ_sum, w_integ_n_ext;
    logic signed [23:0] w_integ_n;
    logic signed [24:0] w_p_term, w_i_term, w_sum, w_sum_neg;
    logic [15:0]        w_adj_calc;
    logic [16:0]        w_err_mag;
    logic               w_in_win;
    logic               w_unused_accum_lo;

    // Only the integer bit-cell phase matters for the detector.
    assign w_unused_accum_lo = ^phase_accum[15:0];

    // An edge is only taken once the loop has left IDLE.
    assign w_accept = enable && flux_edge && (r_state != ST_IDLE);

    // Gain pair chosen by the state before this edge updates it.
    assign w_kp = (r_state == ST_TRK) ? KP_TRK : KP_ACQ;
    assign w_ki = (r_state == ST_TRK) ? KI_TRK : KI_ACQ;

    // Saturating integrator, shifted PI sum, clamp and negate.
    always_comb begin
        w_e_ext     = {{9{r_s1_err[15]}}, r_s1_err};
        w_integ_sum = {r_integ[23], r_integ} + w_e_ext;
        if (w_integ_sum > 25'sd8388607) begin
            w_integ_n = 24'sd8388607;
        end else if (w_integ_sum < -25'sd8388607) begin
            w_integ_n = -24'sd8388607;
        end else begin
            w_integ_n = w_integ_sum[23:0];
        end
        w_integ_n_ext = {w_integ_n[23], w_integ_n};
        w_p_term      = w_e_ext >>> w_kp;
        w_i_term      = w_integ_n_ext >>> w_ki;
        w_sum         = w_p_term + w_i_term;
        w_sum_neg     = -w_sum;
        if (w_sum > 25'sd32767) begin
            w_adj_calc = 16'h8001;
        end else if (w_sum < -25'sd32767) begin
            w_adj_calc = 16'h7FFF;
        end else begin
            w_adj_calc = w_sum_neg[15:0];
        end
        // 17 bits so that |-32768| does not wrap.
        w_err_mag = r_s1_err[15] ? (17'd0 - {r_s1_err[15], r_s1_err})
                                 : {1'b0, r_s1_err};
        w_in_win  = (w_err_mag <= {1'b0, ERR_WIN});
    end

    // Next-state logic: enable/IDLE handling, edge update, timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        w_state_nxt  = r_state;
        w_integ_nxt  = r_integ;
        w_lock_nxt   = r_lock_cnt;
        w_unlock_nxt = r_unlock_cnt;
        w_idle_nxt   = r_idle_cnt;
        w_adj_nxt    = r_phase_adj;
        w_err_nxt    = r_phase_err;
        w_valid_nxt  = 1'b0;

        if (!enable || (r_state == ST_IDLE)) begin
            // Hold the loop cleared; leave IDLE one cycle after enable rises.
            w_state_nxt  = enable ? ST_ACQ : ST_IDLE;
            w_integ_nxt  = '0;
            w_lock_nxt   = '0;
            w_unlock_nxt = '0;
            w_idle_nxt   = '0;
            w_err_nxt    = '0;
        end else begin
            if (w_accept) begin
                w_idle_nxt = '0;
            end else if (r_idle_cnt < TMO_N) begin
                w_idle_nxt = r_idle_cnt + 16'd1;
            end

            if (r_s1_valid) begin
                // An edge's own update wins over a coincident timeout.
                w_integ_nxt = w_integ_n;
                w_adj_nxt   = w_adj_calc;
                w_err_nxt   = r_s1_err;
                w_valid_nxt = 1'b1;
                if (r_state == ST_TRK) begin
                    if (w_in_win) begin
                        w_unlock_nxt = '0;
                    end else if ({1'b0, r_unlock_cnt} + 9'd1 == UNLCK_N) begin
                        w_state_nxt  = ST_ACQ;
                        w_unlock_nxt = '0;
                        w_lock_nxt   = '0;
                    end else begin
                        w_unlock_nxt = r_unlock_cnt + 8'd1;
                    end
                end else begin
                    if (!w_in_win) begin
                        w_lock_nxt = '0;
                    end else if ({1'b0, r_lock_cnt} + 9'd1 == LOCK_N) begin
                        w_state_nxt  = ST_TRK;
                        w_lock_nxt   = '0;
                        w_unlock_nxt = '0;
                    end else begin
                        w_lock_nxt = r_lock_cnt + 8'd1;
                    end
                end
            end else if (r_idle_cnt == TMO_N) begin
                // Edge starvation: fall back to acquisition from scratch.
                w_state_nxt  = ST_ACQ;
                w_integ_nxt  = '0;
                w_lock_nxt   = '0;
                w_unlock_nxt = '0;
            end
        end
    end

    // All loop registers, including the pipeline, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_err     <= '0;
            r_state      <= ST_IDLE;
            r_integ      <= '0;
            r_lock_cnt   <= '0;
            r_unlock_cnt <= '0;
            r_idle_cnt   <= '0;
            r_phase_adj  <= '0;
            r_phase_err  <= '0;
            r_adj_valid  <= 1'b0;
        end else begin
            r_s1_valid   <= w_accept;
            r_s1_err     <= phase_accum[31:16];
            r_state      <= w_state_nxt;
            r_integ      <= w_integ_nxt;
            r_lock_cnt   <= w_lock_nxt;
            r_unlock_cnt <= w_unlock_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_phase_adj  <= w_adj_nxt;
            r_phase_err  <= w_err_nxt;
            r_adj_valid  <= w_valid_nxt;
        end
    end

    assign phase_adj       = r_phase_adj;
    assign phase_adj_valid = r_adj_valid;
    assign phase_err       = r_phase_err;
    assign locked          = (r_state == ST_TRK);
    assign lock_state      = r_state;

endmodule

// File: tb/tb_hdd_dpll_loop_filter.sv
// Scoreboard bench for hdd_dpll_loop_filter: a driver feeds edges and pushes
// reference-model results; a monitor pops and compares on each valid strobe.
module tb_hdd_dpll_loop_filter;

    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flux_edge;
    logic [31:0] phase_accum;
    logic [15:0] phase_adj;
    logic        phase_adj_valid;
    logic [15:0] phase_err;
    logic        locked;
    logic [1:0]  lock_state;

    always #5 clk = ~clk;

    hdd_dpll_loop_filter dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .flux_edge       (flux_edge),
        .phase_accum     (phase_accum),
        .phase_adj       (phase_adj),
        .phase_adj_valid (phase_adj_valid),
        .phase_err       (phase_err),
        .locked          (locked),
        .lock_state      (lock_state)
    );

    typedef struct {
        logic [15:0] adj;
        logic [15:0] err;
        logic        lck;
        logic [1:0]  st;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: 0 idle, 1 acquire, 2 track.
    int m_state, m_integ, m_lock, m_unlock, m_last_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_state  = 0;
        m_integ  = 0;
        m_lock   = 0;
        m_unlock = 0;
    endfunction

    function automatic exp_t model_edge(input logic [15:0] hi);
        exp_t x;
        int e, kp, ki, s, mag;
        e = int'($signed(hi));
        if (cyc - m_last_edge > TIMEOUT) begin
            m_state  = 1;
            m_integ  = 0;
            m_lock   = 0;
            m_unlock = 0;
        end
        m_last_edge = cyc;
        kp = (m_state == 2) ? 4 : 2;
        ki = (m_state == 2) ? 10 : 6;
        m_integ = m_integ + e;
        if (m_integ > 8388607)  m_integ = 8388607;
        if (m_integ < -8388607) m_integ = -8388607;
        s = (e >>> kp) + (m_integ >>> ki);
        if (s > 32767)  s = 32767;
        if (s < -32767) s = -32767;
        x.adj = 16'(-s);
        x.err = hi;
        mag = (e < 0) ? -e : e;
        if (m_state == 1) begin
            if (mag <= 4096) begin
                m_lock++;
                if (m_lock == 16) begin
                    m_state = 2;
                    m_lock  = 0;
                end
            end else begin
                m_lock = 0;
            end
        end else if (m_state == 2) begin
            if (mag > 4096) begin
                m_unlock++;
                if (m_unlock == 4) begin
                    m_state  = 1;
                    m_unlock = 0;
                end
            end else begin
                m_unlock = 0;
            end
        end
        x.lck = (m_state == 2);
        x.st  = 2'(m_state);
        return x;
    endfunction

    // One clock of stimulus; expected result queued for accepted edges.
    task automatic drive(input logic fe, input logic [31:0] acc, input logic push);
        flux_edge   = fe;
        phase_accum = acc;
        if (fe && push && enable && m_state != 0) sb_q.push_back(model_edge(acc[31:16]));
        @(posedge clk);
        #1;
        flux_edge = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0);
    endtask

    // Raise enable; an edge on this first cycle must be ignored.
    task automatic enable_loop(input logic with_edge);
        enable      = 1'b1;
        flux_edge   = with_edge;
        phase_accum = 32'h0100_0000;
        @(posedge clk);
        #1;
        flux_edge   = 1'b0;
        m_state     = 1;
        m_last_edge = cyc;
    endtask

    task automatic disable_loop();
        idle(3);
        enable = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic restart();
        disable_loop();
        idle(1);
        enable_loop(1'b0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (phase_adj_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("stray_valid", {31'd0, phase_adj_valid}, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    check("phase_adj",  {16'd0, phase_adj},  {16'd0, x.adj});
                    check("phase_err",  {16'd0, phase_err},  {16'd0, x.err});
                    check("locked",     {31'd0, locked},     {31'd0, x.lck});
                    check("lock_state", {30'd0, lock_state}, {30'd0, x.st});
                end
            end
        end
    end

    initial begin
        logic [15:0] hi;
        int          wait_n;
        reset       = 1'b1;
        enable      = 1'b0;
        flux_edge   = 1'b0;
        phase_accum = '0;
        model_clear();
        m_last_edge = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_phase_adj",  {16'd0, phase_adj},       32'd0);
        check("rst_valid",      {31'd0, phase_adj_valid}, 32'd0);
        check("rst_phase_err",  {16'd0, phase_err},       32'd0);
        check("rst_locked",     {31'd0, locked},          32'd0);
        check("rst_lock_state", {30'd0, lock_state},      32'd0);

        // Edge on the IDLE->ACQUIRE cycle is dropped, then a single edge.
        enable_loop(1'b1);
        check("acq_entered", {30'd0, lock_state}, 32'd1);
        drive(1'b1, 32'h0100_0000, 1'b1);
        idle(4);

        // Lock with 16 small errors, lose it with 4 large ones.
        restart();
        for (int i = 0; i < 16; i++) drive(1'b1, {16'h0010, 16'($urandom)}, 1'b1);
        idle(3);
        check("locked_after_16", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 4; i++) drive(1'b1, {16'h2000, 16'($urandom)}, 1'b1);
        idle(3);
        check("unlocked_state", {30'd0, lock_state}, 32'd1);

        // Integrator and output saturation, both polarities, back to back.
        restart();
        for (int i = 0; i < 300; i++) drive(1'b1, 32'h7FFF_0000, 1'b1);
        idle(3);
        check("sat_pos_adj", {16'd0, phase_adj}, 32'h8001);
        restart();
        for (int i = 0; i < 300; i++) drive(1'b1, 32'h8000_0000, 1'b1);
        idle(3);
        check("sat_neg_adj", {16'd0, phase_adj}, 32'h7FFF);

        // Starvation timeout from TRACK, then a fresh integrator.
        restart();
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h0010_0000, 1'b1);
        idle(1000);
        check("still_locked", {31'd0, locked}, 32'd1);
        idle(40);
        check("timeout_locked",     {31'd0, locked},     32'd0);
        check("timeout_lock_state", {30'd0, lock_state}, 32'd1);
        drive(1'b1, 32'h0100_0000, 1'b1);
        idle(3);
        check("post_timeout_adj", {16'd0, phase_adj}, 32'hFFBC);

        // Randomized edges with random spacing including back-to-back.
        restart();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(3) != 0) hi = 16'($signed($urandom_range(9216)) - 4608);
            else                        hi = 16'($urandom);
            drive(1'b1, {hi, 16'($urandom)}, 1'b1);
            idle(int'($urandom_range(2)));
        end

        // Enable dropped one cycle after an edge: no strobe, back to IDLE.
        idle(3);
        drive(1'b1, 32'h0100_0000, 1'b0);
        enable = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        model_clear();
        idle(3);
        check("flush_lock_state", {30'd0, lock_state}, 32'd0);
        check("flush_phase_err",  {16'd0, phase_err},  32'd0);

        // Reset mid-operation clears the in-flight edge.
        enable_loop(1'b0);
        drive(1'b1, 32'h0100_0000, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b0;
        model_clear();
        check("midrst_lock_state", {30'd0, lock_state},      32'd0);
        check("midrst_valid",      {31'd0, phase_adj_valid}, 32'd0);
        check("midrst_phase_adj",  {16'd0, phase_adj},       32'd0);
        idle(3);

        // Drain: every queued expectation must have been consumed.
        wait_n = 0;
        while (sb_q.size() != 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
